// File: rtl/ugv_disp_pkg.sv
// Shared display definitions: digit width, blank code, decimal ceiling and
// the converter FSM state type. The display multiplexer uses BLANK_DIGIT too.
package ugv_disp_pkg;

    localparam int unsigned DIGIT_W     = 32'd4;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam int unsigned MAX_DEC     = 32'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_bcd8.sv
// Sequential 27-bit binary to 8-digit BCD converter for the 8-digit display.
// One conversion takes 28 edges from the sampling of start to done. Inputs
// above 99,999,999 saturate to all nines and raise ovf; optional
// leading-zero blanking replaces unused upper digits with the blank code.
module bin_to_bcd8
    import ugv_disp_pkg::*;
#(
    parameter int BIN_W = 27,
    parameter int NDIG  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [3:0]       d6,
    output logic [3:0]       d7
);

    localparam int               BCD_W    = NDIG * DIGIT_W;
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_DEC);
    localparam logic [4:0]       ITER_CNT = 5'(BIN_W);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_fin;

    logic [BIN_W-1:0]     r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_adj;
    logic [4:0]           r_cnt;
    logic                 r_blank;
    logic                 r_ovf_pend;

    logic [DIGIT_W-1:0]   w_disp [NDIG];
    logic [DIGIT_W-1:0]   w_nib;
    logic                 w_lead;

    logic [DIGIT_W-1:0]   r_dig  [NDIG];
    logic                 r_done;
    logic                 r_ovf;

    // Per-digit +3 correction applied to the BCD half before every shift.
    genvar g;
    for (g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_bcd[g*DIGIT_W +: DIGIT_W]),
            .o_nib (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // FSM state register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CONV: begin
                w_shift = 1'b1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_CONV;
                end
            end
            ST_FINISH: begin
                w_fin       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath: capture operands, then adjust-and-shift per cycle.
    // A bit falling off the top digit can only happen for values beyond eight
    // digits, so it is folded into the pending overflow as a cross-check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= {BIN_W{1'b0}};
            r_bcd      <= {BCD_W{1'b0}};
            r_cnt      <= 5'd0;
            r_blank    <= 1'b0;
            r_ovf_pend <= 1'b0;
        end else if (w_load) begin
            r_bin      <= bin;
            r_bcd      <= {BCD_W{1'b0}};
            r_cnt      <= ITER_CNT;
            r_blank    <= blank_lz;
            r_ovf_pend <= (bin > MAX_BIN);
        end else if (w_shift) begin
            r_bcd      <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin      <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt      <= r_cnt - 5'd1;
            r_ovf_pend <= r_ovf_pend | w_adj[BCD_W-1];
        end else begin
            r_bin      <= r_bin;
            r_bcd      <= r_bcd;
            r_cnt      <= r_cnt;
            r_blank    <= r_blank;
            r_ovf_pend <= r_ovf_pend;
        end
    end

    // Display formatting: saturate on overflow, otherwise blank leading zeros
    // from the top down while never blanking the units digit.
    always_comb begin
        w_lead = 1'b1;
        w_nib  = {DIGIT_W{1'b0}};
        for (int i = 0; i < NDIG; i++) begin
            w_disp[i] = {DIGIT_W{1'b0}};
        end
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_nib = r_bcd[i*DIGIT_W +: DIGIT_W];
            if (r_ovf_pend) begin
                w_disp[i] = 4'd9;
            end else if (r_blank && w_lead && (i != 0) && (w_nib == 4'd0)) begin
                w_disp[i] = BLANK_DIGIT;
            end else begin
                w_disp[i] = w_nib;
            end
            w_lead = w_lead & (w_nib == 4'd0);
        end
    end

    // Output registers: digits and ovf only change on FINISH; done pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                r_dig[i] <= {DIGIT_W{1'b0}};
            end
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_dig <= w_disp;
                r_ovf <= r_ovf_pend;
            end else begin
                r_dig <= r_dig;
                r_ovf <= r_ovf;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign d0   = r_dig[0];
    assign d1   = r_dig[1];
    assign d2   = r_dig[2];
    assign d3   = r_dig[3];
    assign d4   = r_dig[4];
    assign d5   = r_dig[5];
    assign d6   = r_dig[6];
    assign d7   = r_dig[7];

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Scoreboard bench for bin_to_bcd8: stimulus pushes the reference result at
// each accepted start, an independent monitor pops and compares on done.
module tb_bin_to_bcd8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [26:0] bin;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;

    typedef struct {
        logic [31:0] dig;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    logic prev_done;

    bin_to_bcd8 #(.BIN_W(27), .NDIG(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6),
        .d7       (d7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by division, blanking by magnitude.
    function automatic logic [32:0] ref_model(input int unsigned v, input bit bl);
        logic [31:0] d;
        int unsigned t;
        int unsigned p;
        bit          ov;
        ov = (v > 32'd99_999_999);
        t  = ov ? 32'd99_999_999 : v;
        p  = 1;
        d  = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (bl && !ov && i > 0 && v < p) d[i*4 +: 4] = 4'hF;
            else                            d[i*4 +: 4] = 4'((t / p) % 10);
            p = p * 10;
        end
        return {ov, d};
    endfunction

    function automatic logic [31:0] digits();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned v, input bit bl);
        logic [32:0] r;
        exp_t e;
        r     = ref_model(v, bl);
        e.dig = r[31:0];
        e.ovf = r[32];
        e.acc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", {63'd0, busy}, 64'd0);
    endtask

    // One start pulse at a negedge; the following posedge samples it.
    task automatic convert(input int unsigned v, input bit bl);
        wait_idle();
        bin      = v[26:0];
        blank_lz = bl;
        start    = 1'b1;
        push_exp(v, bl);
        @(negedge clk);
        start    = 1'b0;
        bin      = 27'($urandom);
        blank_lz = 1'($urandom);
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_single_cycle", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digits", {32'd0, digits()}, {32'd0, e.dig});
                check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                check("latency", 64'(cyc - e.acc), 64'd28);
            end
        end
        prev_done <= done;
    end

    initial begin
        int unsigned v;
        int          k;
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        bin       = 27'd0;
        blank_lz  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_digits", {32'd0, digits()}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values, including saturation boundaries and blanking.
        convert(12345678, 1'b0);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            bin = 27'($urandom);
            @(negedge clk);
        end
        check("hold_between", {32'd0, digits()}, 64'h12345678);
        convert(305, 1'b1);
        convert(0, 1'b1);
        convert(0, 1'b0);
        convert(7, 1'b1);
        convert(10000000, 1'b1);
        convert(100000000, 1'b0);
        convert(134217727, 1'b1);
        convert(99999999, 1'b0);
        convert(99999999, 1'b1);

        // Second start mid-conversion must be ignored.
        convert(87654321, 1'b1);
        repeat (9) @(negedge clk);
        bin   = 27'd555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start held high: each result accepted in the IDLE cycle with done.
        bin      = 27'd11;
        blank_lz = 1'b1;
        start    = 1'b1;
        push_exp(11, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            bin      = 27'($urandom);
            blank_lz = 1'($urandom);
            k = 0;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("held_done_seen", {63'd0, done}, 64'd1);
            if (n < 4) begin
                v        = $urandom_range(99999999, 0);
                bin      = v[26:0];
                blank_lz = n[0];
                push_exp(v, n[0]);
            end else begin
                start = 1'b0;
            end
        end
        wait_idle();

        // Reset in the middle of a conversion: no done, outputs cleared.
        convert(31415926, 1'b0);
        void'(exp_q.pop_back());
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_ovf", {63'd0, ovf}, 64'd0);
        check("midrst_digits", {32'd0, digits()}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(negedge clk);
        check("midrst_no_done_queue", 64'(exp_q.size()), 64'd0);
        convert(42, 1'b0);

        // Randomized conversions, mostly in range with occasional overflow.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(15, 0) == 0) v = $urandom & 32'h07FF_FFFF;
            else                            v = $urandom_range(99999999, 0);
            convert(v, 1'($urandom));
        end

        wait_idle();
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
